// File: rtl/angle_msg_tx.sv
// Serialises a 16-bit angle/command word into two uart_tx bytes (high byte first)
// with a guaranteed idle gap between bytes. Define ANGLE_MSG_TX_REFRESH_EN for periodic resend.
module angle_msg_tx #(
  parameter int GAP_CYCLES     = 240,
  parameter int BUSY_TIMEOUT   = 16,
  parameter int REFRESH_CYCLES = 2400000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] msg_in,
  input  logic        msg_valid,
  output logic        msg_ready,
  output logic        start_tx,
  output logic [7:0]  data_to_tx,
  input  logic        tx_busy,
  output logic        msg_done,
  output logic        tx_error
);

  localparam int MAX_GT = (GAP_CYCLES > BUSY_TIMEOUT) ? GAP_CYCLES : BUSY_TIMEOUT;
`ifdef ANGLE_MSG_TX_REFRESH_EN
  localparam int REFRESH_SPAN = REFRESH_CYCLES;
`else
  // Refresh period is accepted for interface compatibility but has no effect here.
  localparam int REFRESH_SPAN = 0 * REFRESH_CYCLES;
`endif
  localparam int CNT_MAX = (REFRESH_SPAN > MAX_GT) ? REFRESH_SPAN : MAX_GT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    IDLE, SEND_HI, WAIT_BUSY_HI, WAIT_FREE_HI, GAP, SEND_LO, WAIT_BUSY_LO, WAIT_FREE_LO
  } state_t;

  state_t             state, state_nxt;
  logic [15:0]        word, word_nxt;
  logic [7:0]         data_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic               err_nxt, done_nxt;
`ifdef ANGLE_MSG_TX_REFRESH_EN
  logic [CNT_W-1:0]   rcnt, rcnt_nxt;
  logic               have_word, have_nxt;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      word       <= 16'h0000;
      data_to_tx <= 8'h00;
      cnt        <= '0;
      tx_error   <= 1'b0;
      msg_done   <= 1'b0;
`ifdef ANGLE_MSG_TX_REFRESH_EN
      rcnt       <= '0;
      have_word  <= 1'b0;
`endif
    end else begin
      state      <= state_nxt;
      word       <= word_nxt;
      data_to_tx <= data_nxt;
      cnt        <= cnt_nxt;
      tx_error   <= err_nxt;
      msg_done   <= done_nxt;
`ifdef ANGLE_MSG_TX_REFRESH_EN
      rcnt       <= rcnt_nxt;
      have_word  <= have_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt = state;
    word_nxt  = word;
    data_nxt  = data_to_tx;
    cnt_nxt   = cnt;
    err_nxt   = tx_error;
    done_nxt  = 1'b0;
    start_tx  = 1'b0;
    msg_ready = 1'b0;
`ifdef ANGLE_MSG_TX_REFRESH_EN
    rcnt_nxt  = '0;
    have_nxt  = have_word;
`endif
    case (state)
      IDLE: begin
        msg_ready = ~reset;
        if (msg_valid) begin
          word_nxt  = msg_in;
          data_nxt  = msg_in[15:8];
          err_nxt   = 1'b0;
          state_nxt = SEND_HI;
`ifdef ANGLE_MSG_TX_REFRESH_EN
          have_nxt  = 1'b1;
        end else if (have_word && rcnt == CNT_W'(REFRESH_CYCLES - 1)) begin
          data_nxt  = word[15:8];
          state_nxt = SEND_HI;
        end else if (have_word) begin
          rcnt_nxt  = rcnt + CNT_W'(1);
`endif
        end
      end
      SEND_HI: begin
        start_tx  = 1'b1;
        cnt_nxt   = '0;
        state_nxt = WAIT_BUSY_HI;
      end
      // A busy level already present counts as the rise; no fresh edge is required.
      WAIT_BUSY_HI, WAIT_BUSY_LO: begin
        if (tx_busy) begin
          state_nxt = (state == WAIT_BUSY_HI) ? WAIT_FREE_HI : WAIT_FREE_LO;
        end else if (cnt == CNT_W'(BUSY_TIMEOUT - 1)) begin
          err_nxt   = 1'b1;
          state_nxt = IDLE;
        end else begin
          cnt_nxt   = cnt + CNT_W'(1);
        end
      end
      WAIT_FREE_HI: begin
        if (!tx_busy) begin
          cnt_nxt   = '0;
          state_nxt = GAP;
        end
      end
      GAP: begin
        if (cnt == CNT_W'(GAP_CYCLES - 1)) begin
          data_nxt  = word[7:0];
          state_nxt = SEND_LO;
        end else begin
          cnt_nxt   = cnt + CNT_W'(1);
        end
      end
      SEND_LO: begin
        start_tx  = 1'b1;
        cnt_nxt   = '0;
        state_nxt = WAIT_BUSY_LO;
      end
      WAIT_FREE_LO: begin
        if (!tx_busy) begin
          done_nxt  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_angle_msg_tx.sv
// Bench for angle_msg_tx: uart_tx busy model, cycle-level message timing model and scoreboard.
module tb_angle_msg_tx;
  localparam int GAP = 20;
  localparam int TMO = 16;
  localparam int REF = 1000;

  logic        clk24 = 1'b0;
  logic        reset;
  logic [15:0] msg_in;
  logic        msg_valid;
  logic        msg_ready;
  logic        start_tx;
  logic [7:0]  data_to_tx;
  logic        tx_busy = 1'b0;
  logic        msg_done;
  logic        tx_error;

  angle_msg_tx #(.GAP_CYCLES(GAP), .BUSY_TIMEOUT(TMO), .REFRESH_CYCLES(REF)) dut (
    .clk(clk24), .reset(reset), .msg_in(msg_in), .msg_valid(msg_valid), .msg_ready(msg_ready),
    .start_tx(start_tx), .data_to_tx(data_to_tx), .tx_busy(tx_busy), .msg_done(msg_done),
    .tx_error(tx_error)
  );

  always #5 clk24 = ~clk24;

  int cyc = 0;
  always @(posedge clk24) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Observed traffic and reference expectations.
  int         st_cyc[$];
  logic [7:0] st_byte[$];
  int         dn_cyc[$];
  int         exp_st_cyc[$];
  logic [7:0] exp_st_byte[$];
  int         exp_dn_cyc[$];

  // uart_tx stand-in: busy rises the cycle after start_tx, lasts busy_len cycles.
  logic       start_q = 1'b0;
  int         left = 0;
  bit         stuck = 1'b0;
  int         busy_len = 110;
  logic [7:0] last_byte = 8'h00;

  always @(negedge clk24) begin
    start_q <= start_tx;
    if (start_tx === 1'b1) begin
      st_cyc.push_back(cyc);
      st_byte.push_back(data_to_tx);
      last_byte <= data_to_tx;
    end
    if (msg_done === 1'b1) dn_cyc.push_back(cyc);
    if (tx_busy && !reset) chk("data_hold", {24'h0, data_to_tx}, {24'h0, last_byte});
  end

  always @(posedge clk24) begin
    if (reset) begin
      tx_busy <= 1'b0;
      left    <= 0;
    end else if (start_q && !stuck) begin
      tx_busy <= 1'b1;
      left    <= busy_len;
    end else if (left > 1) begin
      left    <= left - 1;
    end else if (left == 1) begin
      left    <= 0;
      tx_busy <= 1'b0;
    end
  end

  // Timing of a full message accepted in cycle a: high byte starts at a+1, busy ends
  // busy_len cycles later, low byte starts GAP+1 cycles after busy is first low,
  // msg_done the cycle after busy is first low again.
  task automatic expect_msg(input int a, input logic [15:0] w, output int done);
    int hs, ls;
    hs = a + 1;
    ls = hs + busy_len + 1 + GAP + 1;
    done = ls + busy_len + 2;
    exp_st_cyc.push_back(hs);  exp_st_byte.push_back(w[15:8]);
    exp_st_cyc.push_back(ls);  exp_st_byte.push_back(w[7:0]);
    exp_dn_cyc.push_back(done);
  endtask

  task automatic check_all(input string tag);
    int n;
    chk($sformatf("%s_nstart", tag), st_cyc.size(), exp_st_cyc.size());
    n = (st_cyc.size() < exp_st_cyc.size()) ? st_cyc.size() : exp_st_cyc.size();
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s_start%0d_cyc", tag, i), st_cyc[i], exp_st_cyc[i]);
      chk($sformatf("%s_start%0d_byte", tag, i), {24'h0, st_byte[i]}, {24'h0, exp_st_byte[i]});
    end
    chk($sformatf("%s_ndone", tag), dn_cyc.size(), exp_dn_cyc.size());
    n = (dn_cyc.size() < exp_dn_cyc.size()) ? dn_cyc.size() : exp_dn_cyc.size();
    for (int i = 0; i < n; i++)
      chk($sformatf("%s_done%0d_cyc", tag, i), dn_cyc[i], exp_dn_cyc[i]);
    st_cyc.delete(); st_byte.delete(); dn_cyc.delete();
    exp_st_cyc.delete(); exp_st_byte.delete(); exp_dn_cyc.delete();
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk24);
  endtask

  task automatic send(input logic [15:0] w, output int a);
    @(negedge clk24);
    chk("ready_at_accept", {31'h0, msg_ready}, 32'h1);
    msg_valid = 1'b1;
    msg_in    = w;
    a         = cyc;
    @(negedge clk24);
    msg_valid = 1'b0;
    msg_in    = 16'($urandom);
  endtask

  initial begin
    int a, d, d2;
    logic [15:0] w;
    reset = 1'b1; msg_valid = 1'b0; msg_in = 16'h0000;
    repeat (3) @(negedge clk24);
    chk("rst_ready", {31'h0, msg_ready}, 32'h0);
    chk("rst_start", {31'h0, start_tx}, 32'h0);
    chk("rst_data", {24'h0, data_to_tx}, 32'h0);
    chk("rst_done", {31'h0, msg_done}, 32'h0);
    chk("rst_err", {31'h0, tx_error}, 32'h0);
    reset = 1'b0;
    @(negedge clk24);
    chk("ready_after_rst", {31'h0, msg_ready}, 32'h1);

    // Single word, long busy.
    busy_len = 110;
    send(16'hA5C3, a);
    expect_msg(a, 16'hA5C3, d);
    wait_until(d + 3);
    check_all("basic");
    chk("basic_err", {31'h0, tx_error}, 32'h0);

    // Back-to-back with msg_valid held; msg_in changes after first acceptance.
    busy_len = 12;
    @(negedge clk24);
    msg_valid = 1'b1; msg_in = 16'h0123; a = cyc;
    @(negedge clk24);
    msg_in = 16'h0FFF;
    expect_msg(a, 16'h0123, d);
    expect_msg(d, 16'h0FFF, d2);
    wait_until(d);
    chk("b2b_ready_on_done", {31'h0, msg_ready}, 32'h1);
    chk("b2b_done_pulse", {31'h0, msg_done}, 32'h1);
    @(negedge clk24);
    msg_valid = 1'b0;
    wait_until(d2 + 3);
    check_all("b2b");

    // msg_valid pulsed while busy is ignored.
    busy_len = 60;
    send(16'h2468, a);
    expect_msg(a, 16'h2468, d);
    wait_until(a + 30);
    chk("busy_ready", {31'h0, msg_ready}, 32'h0);
    msg_valid = 1'b1; msg_in = 16'h1111;
    @(negedge clk24);
    msg_valid = 1'b0;
    wait_until(d + 5);
    check_all("ignore");

    // Randomized words and busy lengths.
    for (int i = 0; i < 6; i++) begin
      busy_len = $urandom_range(2, 40);
      repeat ($urandom_range(0, 8)) @(negedge clk24);
      w = 16'($urandom);
      send(w, a);
      expect_msg(a, w, d);
      wait_until(d + 1);
    end
    wait_until(cyc + 2);
    check_all("rand");

    // Busy never rises: timeout.
    stuck = 1'b1;
    send(16'h7E81, a);
    exp_st_cyc.push_back(a + 1); exp_st_byte.push_back(8'h7E);
    wait_until(a + TMO + 1);
    chk("tmo_err_before", {31'h0, tx_error}, 32'h0);
    chk("tmo_ready_before", {31'h0, msg_ready}, 32'h0);
    @(negedge clk24);
    chk("tmo_err", {31'h0, tx_error}, 32'h1);
    chk("tmo_ready", {31'h0, msg_ready}, 32'h1);
    chk("tmo_no_done", {31'h0, msg_done}, 32'h0);
    wait_until(a + 60);
    check_all("tmo");
    chk("tmo_err_sticky", {31'h0, tx_error}, 32'h1);
    stuck = 1'b0;
    busy_len = 10;
    send(16'h3C5A, a);
    chk("tmo_err_cleared", {31'h0, tx_error}, 32'h0);
    expect_msg(a, 16'h3C5A, d);
    wait_until(d + 3);
    check_all("after_tmo");

    // Reset in the inter-byte gap.
    busy_len = 10;
    send(16'hBEEF, a);
    exp_st_cyc.push_back(a + 1); exp_st_byte.push_back(8'hBE);
    wait_until(a + 15);
    reset = 1'b1;
    @(negedge clk24);
    chk("midrst_ready", {31'h0, msg_ready}, 32'h0);
    chk("midrst_start", {31'h0, start_tx}, 32'h0);
    chk("midrst_data", {24'h0, data_to_tx}, 32'h0);
    reset = 1'b0;
    @(negedge clk24);
    chk("midrst_ready_after", {31'h0, msg_ready}, 32'h1);
    wait_until(a + 15 + 3 * GAP);
    check_all("midrst");
    send(16'h00FF, a);
    expect_msg(a, 16'h00FF, d);
    wait_until(d + 3);
    check_all("post_rst");

    // Refresh behaviour.
    send(16'h0456, a);
    expect_msg(a, 16'h0456, d);
`ifdef ANGLE_MSG_TX_REFRESH_EN
    expect_msg(d + REF - 1, 16'h0456, d2);
    wait_until(d2 + 3);
`else
    wait_until(d + 5000);
`endif
    check_all("refresh");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
